alu_sweep_capture: RTL and testbench
====================================

Name: alu_sweep_capture

Overview:
- Hardware sequencer and result capture engine for the combinational ALU (ports A, B, Cin, Card[4:0] in; F, Cout, Zero out).
- On `start`, it latches one operand set and steps Card through codes 1..15 and then 0, holding each code for SETTLE cycles.
- It captures F/Cout/Zero for each code into a 16-entry result buffer and counts Zero hits.
- Software or a bench reads results back through a registered read port. The block is the on-chip response and collection side of the ALU operation sweep.

Parameters:
- WIDTH, 32, operand and result width.
- SETTLE, 1, cycles each Card code is held before capture; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- op_a  input  WIDTH  operand A, latched on accepted start.
- op_b  input  WIDTH  operand B, latched on accepted start.
- op_cin  input  1  carry-in, latched on accepted start.
- alu_a  output  WIDTH  drives ALU A.
- alu_b  output  WIDTH  drives ALU B.
- alu_cin  output  1  drives ALU Cin.
- alu_card  output  5  drives ALU Card.
- alu_f  input  WIDTH  ALU F.
- alu_cout  input  1  ALU Cout.
- alu_zero  input  1  ALU Zero.
- busy  output  1  high while a sweep runs.
- done  output  1  one-cycle pulse when a sweep completes.
- results_valid  output  1  buffer holds a complete sweep.
- zero_cnt  output  5  number of captured entries with Zero=1 (0..16).
- rd_addr  input  4  buffer read index.
- rd_f  output  WIDTH  F of entry rd_addr, registered.
- rd_cout  output  1  Cout of entry rd_addr, registered.
- rd_zero  output  1  Zero of entry rd_addr, registered.

Behaviour:

Reset
- Asynchronous, active-high.
- All outputs go to 0: alu_a, alu_b, alu_cin, alu_card, busy, done, results_valid, zero_cnt, rd_*.
- All 16 buffer entries, the index counter, and the settle counter clear to 0.
- State returns to IDLE.
- Reset mid-sweep aborts the sweep; no partial results_valid.

States
- IDLE:
  - alu_card = 0; busy = 0.
  - start=1 at edge E0: latch op_a/op_b/op_cin onto alu_a/alu_b/alu_cin, idx=0, alu_card=1, settle counter=0, zero_cnt=0, results_valid=0, go to RUN.
- RUN:
  - busy = 1; alu_card = (idx+1) mod 16.
  - The settle counter increments every cycle. On the edge where it equals SETTLE-1:
    - write buffer[idx] <= {alu_cout, alu_zero, alu_f};
    - zero_cnt += alu_zero;
    - clear the settle counter;
    - idx += 1.
  - Captures occur at edges E0 + k*SETTLE, k = 1..16.
  - After the capture with idx=15: go to DONE, alu_card = 0, busy = 0.
- DONE:
  - Lasts exactly one cycle: done = 1, results_valid = 1, then go to IDLE.

Buffer mapping
- buffer[i] holds the result for Card = (i+1) mod 16, so entry 15 holds Card 0.

Timing and concurrency rules
- start is ignored in RUN and DONE; there is no queuing.
- Operands are stable for the whole sweep; changes on op_* during RUN have no effect.
- Read port: rd_* <= buffer[rd_addr] every clock, giving 1-cycle latency. It is legal in any state.
  - During RUN it returns current contents: old sweep data for entries not yet overwritten.
  - A read of an entry written on the same edge returns the pre-write value.
- results_valid stays 1 from DONE until the next accepted start or reset.
- A sweep lasts 16*SETTLE cycles in RUN plus 1 cycle in DONE.
- alu_cin, alu_a, and alu_b keep the latched values after completion, until the next start.

Test Plan:
- Stub ALU used by all scenarios: alu_f = zero-extended alu_card, alu_zero = (alu_card==0), alu_cout = alu_card[0].
- SETTLE=1, op_a=32'h00000010, op_b=32'h00000008, op_cin=1, start pulse:
  - alu_card reads 1,2,...,15,0 on consecutive cycles and alu_a/alu_b/alu_cin show the operands;
  - done pulses exactly 17 cycles after the start edge;
  - zero_cnt=1; results_valid=1.
- Readback after the first scenario, rd_addr=0..15:
  - rd_f = 1..15,0 one cycle after each address;
  - rd_zero=1 only at addr 15;
  - rd_cout=1 at even addresses 0,2,...,14 (odd Card codes).
- SETTLE=3: each alu_card value is held 3 cycles; done occurs 49 cycles after the start edge; buffer contents are identical to the first scenario.
- Start held high for 5 cycles, plus a second start pulse mid-sweep: exactly one sweep runs; done pulses once; the sweep length is unchanged.
- Assert rst at alu_card=7 mid-sweep:
  - busy, alu_card, zero_cnt, and results_valid go to 0 immediately, without waiting for a clock edge;
  - all rd_f reads return 0;
  - a following start runs a full, correct sweep.
- Second sweep after completion with op_a=32'hFFFFFFFF: results_valid drops on the start edge and rises again at done; zero_cnt restarts from 0 and ends at 1.

Source files
------------

// File: rtl/alu_sweep_capture.sv
// Sweeps the ALU Card code 1..15,0 over one latched operand set and
// captures F/Cout/Zero per code into a 16-entry buffer with a registered read port.
module alu_sweep_capture #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [4:0]       alu_card,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout,
  input  logic             alu_zero,
  output logic             busy,
  output logic             done,
  output logic             results_valid,
  output logic [4:0]       zero_cnt,
  input  logic [3:0]       rd_addr,
  output logic [WIDTH-1:0] rd_f,
  output logic             rd_cout,
  output logic             rd_zero
);

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned ENT_W   = WIDTH + 2;
  localparam logic [IDX_W-1:0] SETTLE_LAST = IDX_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(ENTRIES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             cin_q,    cin_d;
  logic [IDX_W-1:0] card_q,   card_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [IDX_W-1:0] settle_q, settle_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             valid_q,  valid_d;
  logic [CNT_W-1:0] zcnt_q,   zcnt_d;
  logic [ENT_W-1:0] rd_q,     rd_d;
  logic [ENT_W-1:0] buf_q [ENTRIES];
  logic [ENT_W-1:0] buf_d [ENTRIES];

  // Entry layout: {cout, zero, f}
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    card_d   = card_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    zcnt_d   = zcnt_q;
    buf_d    = buf_q;
    rd_d     = buf_q[rd_addr];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = op_a;
          b_d      = op_b;
          cin_d    = op_cin;
          idx_d    = '0;
          card_d   = IDX_W'(1);
          settle_d = '0;
          zcnt_d   = '0;
          valid_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (settle_q == SETTLE_LAST) begin
          buf_d[idx_q] = {alu_cout, alu_zero, alu_f};
          zcnt_d       = zcnt_q + CNT_W'(alu_zero);
          settle_d     = '0;
          idx_d        = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            card_d  = '0;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            card_d = card_q + IDX_W'(1);
          end
        end else begin
          settle_d = settle_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      card_q   <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      zcnt_q   <= '0;
      rd_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      card_q   <= card_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      zcnt_q   <= zcnt_d;
      rd_q     <= rd_d;
      buf_q    <= buf_d;
    end
  end

  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_cin       = cin_q;
  assign alu_card      = {1'b0, card_q};
  assign busy          = busy_q;
  assign done          = done_q;
  assign results_valid = valid_q;
  assign zero_cnt      = zcnt_q;
  assign rd_f          = rd_q[WIDTH-1:0];
  assign rd_zero       = rd_q[WIDTH];
  assign rd_cout       = rd_q[WIDTH+1];

endmodule

// File: tb/tb_alu_sweep_capture.sv
// Directed bench for alu_sweep_capture: two instances (SETTLE=1 and SETTLE=3)
// each driving a stub ALU, with a queue-based scoreboard for card and readback values.
module tb_alu_sweep_capture;

  logic        clk, rst, start1, start3, op_cin;
  logic [31:0] op_a, op_b;
  logic [3:0]  rd_addr;

  logic [31:0] a1, b1, f1, rf1, a3, b3, f3, rf3;
  logic        cin1, cout1, zero1, busy1, done1, valid1, rc1, rz1;
  logic        cin3, cout3, zero3, busy3, done3, valid3, rc3, rz3;
  logic [4:0]  card1, zc1, card3, zc3;

  int total = 0;
  int bad   = 0;
  int done1_cnt = 0;
  logic [63:0] exp_q [$];

  // Stub ALU: F = card, Zero = (card==0), Cout = card[0]
  assign f1    = 32'(card1);
  assign zero1 = (card1 == 5'd0);
  assign cout1 = card1[0];
  assign f3    = 32'(card3);
  assign zero3 = (card3 == 5'd0);
  assign cout3 = card3[0];

  alu_sweep_capture #(.WIDTH(32), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .alu_a(a1), .alu_b(b1), .alu_cin(cin1), .alu_card(card1),
    .alu_f(f1), .alu_cout(cout1), .alu_zero(zero1),
    .busy(busy1), .done(done1), .results_valid(valid1), .zero_cnt(zc1),
    .rd_addr(rd_addr), .rd_f(rf1), .rd_cout(rc1), .rd_zero(rz1));

  alu_sweep_capture #(.WIDTH(32), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .alu_a(a3), .alu_b(b3), .alu_cin(cin3), .alu_card(card3),
    .alu_f(f3), .alu_cout(cout3), .alu_zero(zero3),
    .busy(busy3), .done(done3), .results_valid(valid3), .zero_cnt(zc3),
    .rd_addr(rd_addr), .rd_f(rf3), .rd_cout(rc3), .rd_zero(rz3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done1) done1_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full SETTLE=1 sweep from IDLE with a previously valid/invalid buffer
  task automatic run_sweep1(input logic [31:0] a, input logic [31:0] b, input logic cin);
    op_a = a; op_b = b; op_cin = cin; start1 = 1'b1;
    for (int j = 0; j < 16; j++) exp_q.push_back(64'((j + 1) % 16));
    tick();
    start1 = 1'b0;
    chk("valid_drop", 64'(valid1), 64'd0);
    chk("zcnt_clear", 64'(zc1), 64'd0);
    chk("busy_run", 64'(busy1), 64'd1);
    chk("alu_a", 64'(a1), 64'(a));
    chk("alu_b", 64'(b1), 64'(b));
    chk("alu_cin", 64'(cin1), 64'(cin));
    for (int j = 0; j < 16; j++) begin
      chk("card1", 64'(card1), exp_q.pop_front());
      tick();
    end
    chk("busy_end", 64'(busy1), 64'd0);
    chk("card_end", 64'(card1), 64'd0);
    chk("done_early", 64'(done1), 64'd0);
    tick();
    chk("done_17", 64'(done1), 64'd1);
    chk("valid_set", 64'(valid1), 64'd1);
    chk("zcnt_end", 64'(zc1), 64'd1);
    chk("alu_a_hold", 64'(a1), 64'(a));
    tick();
    chk("done_pulse", 64'(done1), 64'd0);
  endtask

  task automatic readback(input logic use3, input logic cleared);
    logic [3:0]  card;
    logic [63:0] obs;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      card = 4'((i + 1) % 16);
      if (cleared) exp_q.push_back(64'd0);
      else exp_q.push_back({30'd0, card[0], (card == 4'd0), 28'd0, card});
      tick();
      obs = use3 ? {30'd0, rc3, rz3, rf3} : {30'd0, rc1, rz1, rf1};
      chk(use3 ? "rd3" : "rd1", obs, exp_q.pop_front());
    end
  endtask

  initial begin
    int dc;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; rd_addr = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_card", 64'(card1), 64'd0);
    chk("rst_valid", 64'(valid1), 64'd0);
    chk("rst_rdf", 64'(rf1), 64'd0);
    rst = 1'b0;
    tick();

    run_sweep1(32'h0000_0010, 32'h0000_0008, 1'b1);
    readback(1'b0, 1'b0);

    // SETTLE=3: each code held three cycles, done 49 cycles after start
    op_a = 32'h0000_0010; op_b = 32'h0000_0008; op_cin = 1'b1; start3 = 1'b1;
    for (int j = 0; j < 48; j++) exp_q.push_back(64'((j / 3 + 1) % 16));
    tick();
    start3 = 1'b0;
    for (int j = 0; j < 48; j++) begin
      chk("card3", 64'(card3), exp_q.pop_front());
      tick();
    end
    chk("done3_early", 64'(done3), 64'd0);
    tick();
    chk("done3_49", 64'(done3), 64'd1);
    chk("zcnt3", 64'(zc3), 64'd1);
    chk("valid3", 64'(valid3), 64'd1);
    readback(1'b1, 1'b0);

    // Held start plus mid-sweep pulse: exactly one sweep of unchanged length
    dc = done1_cnt;
    start1 = 1'b1;
    tick();
    for (int j = 1; j <= 16; j++) begin
      start1 = (j < 5) || (j == 8);
      tick();
      chk("hold_nodone", 64'(done1), 64'd0);
    end
    start1 = 1'b0;
    tick();
    chk("hold_done17", 64'(done1), 64'd1);
    for (int j = 0; j < 20; j++) tick();
    chk("hold_one_done", 64'(done1_cnt - dc), 64'd1);
    chk("hold_idle", 64'(busy1), 64'd0);

    // Asynchronous reset mid-sweep at card 7
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    chk("pre_rst_card", 64'(card1), 64'd7);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy1), 64'd0);
    chk("arst_card", 64'(card1), 64'd0);
    chk("arst_zcnt", 64'(zc1), 64'd0);
    chk("arst_valid", 64'(valid1), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    readback(1'b0, 1'b1);
    run_sweep1(32'h0000_0010, 32'h0000_0008, 1'b1);
    readback(1'b0, 1'b0);

    // Back-to-back sweep after completion with new operand A
    run_sweep1(32'hFFFF_FFFF, 32'h0000_0008, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
